// File: rtl/avalon_ram_pkg.sv
// avalon_ram_pkg: shared region map, default sizes, wait-state encoding and byte-lane merge
package avalon_ram_pkg;
  localparam logic [31:0] BOOT_BASE = 32'hBFC0_0000;
  localparam logic [31:0] DATA_BASE = 32'h0000_0000;
  localparam int INST_WORDS_DEF = 64;
  localparam int DATA_WORDS_DEF = 256;
  typedef enum logic [1:0] {IDLE, WAIT, COMPLETE} ws_t;
  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = be[i] ? wd[8*i+:8] : old[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/avalon_ram_if.sv
// avalon_ram_if: Avalon-MM slave bus bundle
interface avalon_ram_if;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  modport master (output address, write, read, writedata, byteenable, input waitrequest, readdata);
  modport slave (input address, write, read, writedata, byteenable, output waitrequest, readdata);
endinterface

// File: rtl/avalon_ram_waitgen.sv
// avalon_ram_waitgen: wait-state sequencer stalling each transfer for N cycles
module avalon_ram_waitgen
  import avalon_ram_pkg::*;
#(
  parameter int N = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic waitrequest
);
  ws_t state;
  logic [31:0] cnt;
  assign waitrequest = N > 0 && rst_n && req && state != COMPLETE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: if (req && N > 0) begin
          state <= N == 1 ? COMPLETE : WAIT;
          cnt   <= 32'd1;
        end
        WAIT: if (!req) state <= IDLE;
              else if (cnt == 32'(N - 1)) state <= COMPLETE;
              else cnt <= cnt + 32'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/avalon_ram.sv
// avalon_ram: boot + data RAM on an Avalon-MM slave with wait states and level-sensitive boot preload
module avalon_ram
  import avalon_ram_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int INST_WORDS  = INST_WORDS_DEF,
  parameter int DATA_WORDS  = DATA_WORDS_DEF
) (
  input logic        clk,
  input logic        RAM_Reset,
  avalon_ram_if.slave bus,
  input logic [31:0] instruction,
  input logic        inst_input,
  input logic [7:0]  inst_addr
);
  logic [31:0] boot_mem [INST_WORDS];
  logic [31:0] data_mem [DATA_WORDS];
  logic [5:0]  boot_idx, pend_idx;
  logic [7:0]  data_idx;
  logic        boot_hit, data_hit, stall, commit, pl_hit, pend;
  logic [31:0] cur, pend_data;
  logic        unused;
  assign boot_idx = bus.address[7:2];
  assign data_idx = bus.address[9:2];
  assign boot_hit = bus.address[31:8] == BOOT_BASE[31:8] && int'(boot_idx) < INST_WORDS;
  assign data_hit = bus.address - DATA_BASE < 32'(4 * DATA_WORDS);
  assign cur      = boot_hit ? boot_mem[boot_idx] : data_hit ? data_mem[data_idx] : '0;
  assign commit   = bus.write && !stall;
  assign pl_hit   = inst_input && inst_addr[7:2] == boot_idx;
  assign bus.readdata    = bus.read && !bus.write && !stall ? cur : '0;
  assign bus.waitrequest = stall;
  assign unused   = ^{bus.address[1:0], inst_addr[1:0]};
  avalon_ram_waitgen #(.N(WAIT_CYCLES)) u_waitgen (
    .clk         (clk),
    .rst_n       (RAM_Reset),
    .req         (bus.read | bus.write),
    .waitrequest (stall)
  );
  // Boot writes are captured on the edge, then folded into the preload latch so both share one store
  always_ff @(posedge clk or negedge RAM_Reset)
    if (!RAM_Reset) begin
      pend      <= 1'b0;
      pend_idx  <= '0;
      pend_data <= '0;
    end else begin
      pend      <= commit && boot_hit && !pl_hit;
      pend_idx  <= boot_idx;
      pend_data <= merge_bytes(cur, bus.writedata, bus.byteenable);
    end
  always_latch
    for (int i = 0; i < INST_WORDS; i++)
      if (!RAM_Reset) boot_mem[i] <= '0;
      else if (inst_input && inst_addr[7:2] == 6'(i)) boot_mem[i] <= instruction;
      else if (pend && pend_idx == 6'(i)) boot_mem[i] <= pend_data;
  always_ff @(posedge clk or negedge RAM_Reset)
    if (!RAM_Reset) for (int i = 0; i < DATA_WORDS; i++) data_mem[i] <= '0;
    else if (commit && data_hit) data_mem[data_idx] <= merge_bytes(cur, bus.writedata, bus.byteenable);
endmodule

// File: tb/tb_avalon_ram.sv
// tb_avalon_ram: vector table, directed corners and random traffic against a word-array model
module tb_avalon_ram;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0, rst1, inst_input, inst_input1;
  logic [31:0] instruction;
  logic [7:0]  inst_addr;
  avalon_ram_if b0();
  avalon_ram_if b1();
  avalon_ram u0 (.clk(clk), .RAM_Reset(rst0), .bus(b0), .instruction(instruction), .inst_input(inst_input), .inst_addr(inst_addr));
  avalon_ram #(.WAIT_CYCLES(2)) u1 (.clk(clk), .RAM_Reset(rst1), .bus(b1), .instruction(instruction), .inst_input(inst_input1), .inst_addr(inst_addr));
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] boot_m [64];
  logic [31:0] data_m [256];
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] m_rd(input logic [31:0] a);
    if (a[31:8] == 24'hBFC000) return boot_m[a[7:2]];
    if (a < 32'd1024) return data_m[a[9:2]];
    return 32'h0;
  endfunction
  task automatic m_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = m_rd(a);
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b+:8] = d[8*b+:8];
    if (a[31:8] == 24'hBFC000) boot_m[a[7:2]] = w;
    else if (a < 32'd1024) data_m[a[9:2]] = w;
  endtask
  task automatic m_clear();
    foreach (boot_m[i]) boot_m[i] = '0;
    foreach (data_m[i]) data_m[i] = '0;
  endtask
  task automatic wr0(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(posedge clk); #1;
    b0.address = a; b0.writedata = d; b0.byteenable = be; b0.write = 1'b1;
    @(posedge clk); #1;
    b0.write = 1'b0;
    m_wr(a, d, be);
  endtask
  task automatic rd0(input logic [31:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    b0.address = a; b0.read = 1'b1;
    #2 d = b0.readdata;
    chk("wait0_zero", {31'b0, b0.waitrequest}, 32'h0);
    b0.read = 1'b0;
  endtask
  task automatic preload(input logic [7:0] ia, input logic [31:0] ins);
    instruction = ins; inst_addr = ia; inst_input = 1'b1;
    #1 inst_input = 1'b0;
    #1 boot_m[ia[7:2]] = ins;
  endtask
  task automatic xfer1(input bit is_wr, input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd, output int hi);
    bit done;
    done = 1'b0; hi = 0; rd = '0;
    @(posedge clk); #1;
    b1.address = a; b1.writedata = d; b1.byteenable = 4'hF; b1.write = is_wr; b1.read = !is_wr;
    for (int c = 0; c < 8 && !done; c++) begin
      #1;
      if (!b1.waitrequest) begin
        rd = b1.readdata;
        done = 1'b1;
      end else begin
        hi++;
        if (!is_wr) chk("rd_zero_stalled", b1.readdata, 32'h0);
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL wait_budget: waitrequest still %b after %0d cycles, required low", b1.waitrequest, hi);
    end
    @(posedge clk); #1;
    b1.write = 1'b0; b1.read = 1'b0;
  endtask
  task automatic add(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic [31:0] exp, input string name);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.be = be; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] got, a, d;
    logic [3:0] be;
    int hi;
    b0.address = '0; b0.write = 0; b0.read = 0; b0.writedata = '0; b0.byteenable = '0;
    b1.address = '0; b1.write = 0; b1.read = 0; b1.writedata = '0; b1.byteenable = '0;
    inst_input1 = 1'b0;
    m_clear();
    rst0 = 1'b0; rst1 = 1'b0;
    instruction = 32'h0BAD_F00D; inst_addr = 8'h3C; inst_input = 1'b1;
    b0.address = 32'hBFC0_003C; b0.read = 1'b1; b1.read = 1'b1;
    #12;
    chk("reset_blocks_preload", b0.readdata, 32'h0);
    chk("reset_wait_low", {31'b0, b1.waitrequest}, 32'h0);
    b1.read = 1'b0;
    rst0 = 1'b1; rst1 = 1'b1;
    #1 chk("preload_resumes", b0.readdata, 32'h0BAD_F00D);
    instruction = 32'h600D_CAFE;
    #1 chk("preload_tracks", b0.readdata, 32'h600D_CAFE);
    inst_input = 1'b0; b0.read = 1'b0;
    boot_m[15] = 32'h600D_CAFE;
    preload(8'h04, 32'h240A_BFC0);
    preload(8'h28, 32'h03E0_0008);
    add(0, 32'hBFC0_0004, 0, 0, 32'h240A_BFC0, "boot_04");
    add(0, 32'hBFC0_0028, 0, 0, 32'h03E0_0008, "boot_28");
    add(0, 32'hBFC0_0000, 0, 0, 32'h0, "boot_00");
    add(1, 32'h0000_0010, 32'h1122_3344, 4'hF, 0, "");
    add(0, 32'h0000_0010, 0, 0, 32'h1122_3344, "data_full");
    add(1, 32'h0000_0010, 32'hAABB_CCDD, 4'h5, 0, "");
    add(0, 32'h0000_0010, 0, 0, 32'h11BB_33DD, "data_be5");
    add(0, 32'h0000_0013, 0, 0, 32'h11BB_33DD, "low_bits_ignored");
    add(0, 32'h4000_0000, 0, 0, 32'h0, "unmapped_rd");
    add(1, 32'h4000_0000, 32'hFFFF_FFFF, 4'hF, 0, "");
    add(0, 32'h4000_0000, 0, 0, 32'h0, "unmapped_rd2");
    add(0, 32'h0000_0010, 0, 0, 32'h11BB_33DD, "data_kept");
    add(0, 32'hBFC0_0004, 0, 0, 32'h240A_BFC0, "boot_kept");
    add(1, 32'hBFC0_0008, 32'hCAFE_BABE, 4'hC, 0, "");
    add(0, 32'hBFC0_0008, 0, 0, 32'hCAFE_0000, "boot_be_c");
    add(1, 32'h0000_03FC, 32'hDEAD_BEEF, 4'hF, 0, "");
    add(0, 32'h0000_03FC, 0, 0, 32'hDEAD_BEEF, "data_last");
    add(0, 32'h0000_0400, 0, 0, 32'h0, "data_end_plus1");
    add(0, 32'hBFC0_0100, 0, 0, 32'h0, "boot_end_plus1");
    foreach (tbl[i])
      if (tbl[i].wr) wr0(tbl[i].addr, tbl[i].data, tbl[i].be);
      else begin
        rd0(tbl[i].addr, got);
        chk(tbl[i].name, got, tbl[i].exp);
      end
    @(posedge clk); #1;
    b0.address = 32'h20; b0.writedata = 32'h55AA_55AA; b0.byteenable = 4'hF; b0.read = 1'b1; b0.write = 1'b1;
    #1 chk("rw_readdata_zero", b0.readdata, 32'h0);
    @(posedge clk); #1;
    b0.read = 1'b0; b0.write = 1'b0;
    m_wr(32'h20, 32'h55AA_55AA, 4'hF);
    rd0(32'h20, got);
    chk("rw_is_write", got, 32'h55AA_55AA);
    @(posedge clk); #1;
    b0.address = 32'hBFC0_000C; b0.writedata = 32'h1111_1111; b0.byteenable = 4'hF; b0.write = 1'b1;
    instruction = 32'h2222_2222; inst_addr = 8'h0C; inst_input = 1'b1;
    @(posedge clk); #1;
    b0.write = 1'b0; inst_input = 1'b0;
    boot_m[3] = 32'h2222_2222;
    rd0(32'hBFC0_000C, got);
    chk("preload_priority", got, 32'h2222_2222);
    for (int n = 0; n < 300; n++) begin
      int r, sel;
      r = $urandom_range(0, 9);
      sel = $urandom_range(0, 2);
      a = sel == 0 ? (32'hBFC0_0000 | ($urandom & 32'hFF)) :
          sel == 1 ? ($urandom & 32'h3FF) : (32'h400 + ($urandom % 32'h3000_0000));
      if (r < 4) begin
        d = $urandom; be = 4'($urandom);
        wr0(a, d, be);
      end else if (r < 9) begin
        rd0(a, got);
        chk("rand_rd", got, m_rd(a));
      end else preload(8'($urandom), $urandom);
    end
    wr0(32'h0, 32'h1234_5678, 4'hF);
    @(posedge clk); #1;
    b0.address = 32'h0; b0.read = 1'b1;
    #1 chk("before_async_reset", b0.readdata, 32'h1234_5678);
    #2 rst0 = 1'b0;
    #1 chk("async_reset_clear", b0.readdata, 32'h0);
    b0.read = 1'b0; rst0 = 1'b1;
    m_clear();
    rd0(32'hBFC0_0004, got);
    chk("boot_cleared", got, 32'h0);
    xfer1(1, 32'h40, 32'hA5A5_A5A5, got, hi);
    chk("w2_wr_hi", 32'(hi), 32'd2);
    xfer1(0, 32'h40, 32'h0, got, hi);
    chk("w2_rd_hi", 32'(hi), 32'd2);
    chk("w2_rd_data", got, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    b1.address = 32'h40; b1.writedata = 32'hFFFF_FFFF; b1.write = 1'b1;
    #1 chk("abort_wr_stall", {31'b0, b1.waitrequest}, 32'h1);
    @(posedge clk); #1;
    b1.write = 1'b0;
    #1 chk("abort_wr_low", {31'b0, b1.waitrequest}, 32'h0);
    @(posedge clk); #1;
    b1.read = 1'b1;
    @(posedge clk); #1;
    b1.read = 1'b0;
    repeat (2) @(posedge clk);
    xfer1(0, 32'h40, 32'h0, got, hi);
    chk("abort_no_write", got, 32'hA5A5_A5A5);
    chk("abort_idle_hi", 32'(hi), 32'd2);
    xfer1(0, 32'h4000_0000, 32'h0, got, hi);
    chk("w2_unmapped_hi", 32'(hi), 32'd2);
    chk("w2_unmapped_rd", got, 32'h0);
    xfer1(1, 32'hBFC0_0010, 32'h1357_9BDF, got, hi);
    xfer1(0, 32'hBFC0_0010, 32'h0, got, hi);
    chk("w2_boot_rd", got, 32'h1357_9BDF);
    @(posedge clk); #1;
    b1.address = 32'h44; b1.writedata = 32'h7777_7777; b1.write = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    #1 chk("reset_midxfer_low", {31'b0, b1.waitrequest}, 32'h0);
    @(posedge clk); #1;
    b1.write = 1'b0; rst1 = 1'b1;
    xfer1(0, 32'h44, 32'h0, got, hi);
    chk("reset_midxfer_word", got, 32'h0);
    chk("reset_midxfer_idle", 32'(hi), 32'd2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
